// File: rtl/bram_refill_arbiter.sv
// Shares one BRAM line port between the I-cache and D-cache. Grant is registered (mem_req one cycle after req),
// completion (rdy) is combinational on mem_valid; one transaction in flight, loser waits holding its req.
module bram_refill_arbiter #(
  parameter int ADDR_BITS       = 15,
  parameter int LINE_BITS       = 128,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 i_req,
  input  logic                 i_write,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [LINE_BITS-1:0] i_wdata,
  output logic                 i_rdy,
  input  logic                 d_req,
  input  logic                 d_write,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic                 d_rdy,
  output logic [LINE_BITS-1:0] rdata,
  output logic                 err,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_valid
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] streak;
  logic [7:0] timer;
  logic       grant_d;
  logic       timeout;
  logic       done;

  // Data wins unless the instruction side has already been passed over too often.
  assign grant_d = d_req && !(i_req && (streak >= STREAK_MAX));
  assign timeout = (state != IDLE) && (timer == TIMER_LAST);
  assign done    = i_rdy | d_rdy;
  assign rdata   = err ? '0 : mem_rdata;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    i_rdy     = 1'b0;
    d_rdy     = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_d)    state_nxt = D_BUSY;
        else if (i_req) state_nxt = I_BUSY;
      end
      I_BUSY: begin
        if (mem_valid || timeout) begin
          i_rdy     = 1'b1;
          err       = !mem_valid;
          state_nxt = IDLE;
        end
      end
      D_BUSY: begin
        if (mem_valid || timeout) begin
          d_rdy     = 1'b1;
          err       = !mem_valid;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      streak    <= '0;
      timer     <= '0;
    end else if (state == IDLE) begin
      timer <= '0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_write <= d_write;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        if (!i_req)              streak <= '0;
        else if (streak != 4'hF) streak <= streak + 4'd1;
      end else if (i_req) begin
        mem_req   <= 1'b1;
        mem_write <= i_write;
        mem_addr  <= i_addr;
        mem_wdata <= i_wdata;
        streak    <= '0;
      end else begin
        mem_req <= 1'b0;
      end
    end else if (done) begin
      mem_req <= 1'b0;
      timer   <= '0;
    end else begin
      timer <= timer + 8'd1;
    end
  end

endmodule

// File: tb/tb_bram_refill_arbiter.sv
// Directed bench for bram_refill_arbiter: scoreboard of expected BRAM transactions and rdy completions.
module tb_bram_refill_arbiter;

  logic          HCLK, HRESETn;
  logic          i_req, i_write, i_rdy, d_req, d_write, d_rdy, err;
  logic [14:0]   i_addr, d_addr, mem_addr;
  logic [127:0]  i_wdata, d_wdata, rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_write, mem_valid;

  bram_refill_arbiter #(.ADDR_BITS(15), .LINE_BITS(128), .MAX_DATA_STREAK(4), .TIMEOUT_CYCLES(64)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .i_req(i_req), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata), .i_rdy(i_rdy),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdy(d_rdy),
    .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  typedef struct { logic is_d; logic err; logic [127:0] rdata; int cyc; } rdy_exp_t;
  typedef struct { logic wr; logic [14:0] addr; logic [127:0] wdata; } mem_exp_t;

  rdy_exp_t rdy_q[$];
  mem_exp_t mem_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_txn = 0;

  // BRAM model knobs, written by the stimulus thread at +1, read by the model at +2.
  int           resp_lat = 1;
  bit           resp_en = 1;
  bit           stray_valid = 0;
  logic [127:0] resp_data = '0;
  int           age = 0;
  bit           req_prev = 0;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic expect_txn(input bit is_d, input bit wr, input logic [14:0] addr, input logic [127:0] wdata);
    mem_exp_t m;
    m.wr = wr; m.addr = addr; m.wdata = wdata;
    mem_q.push_back(m);
  endtask

  task automatic expect_rdy(input bit is_d, input bit e, input logic [127:0] rd, input int c);
    rdy_exp_t r;
    r.is_d = is_d; r.err = e; r.rdata = rd; r.cyc = c;
    rdy_q.push_back(r);
  endtask

  // Waits (bounded) for the given rdy, then moves to the following cycle.
  task automatic wait_rdy(input bit is_d);
    bit got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge HCLK);
      if (is_d ? d_rdy : i_rdy) begin
        got = 1;
        break;
      end
    end
    chk(is_d ? "wait_d_rdy" : "wait_i_rdy", 128'(got), 128'(1));
    step();
  endtask

  // BRAM responder: mem_valid after resp_lat cycles of mem_req.
  always @(posedge HCLK) begin
    #2;
    if (mem_req) age = req_prev ? age + 1 : 0;
    req_prev  = mem_req;
    mem_valid = stray_valid | (mem_req && resp_en && (age == resp_lat));
    mem_rdata = resp_data;
  end

  // Completion scoreboard.
  bit rdy_prev = 0;
  always @(negedge HCLK) begin
    rdy_exp_t e;
    if (rdy_prev) chk("mem_req_gap", 128'(mem_req), 128'(0));
    if (i_rdy || d_rdy) begin
      chk("rdy_exclusive", 128'(i_rdy & d_rdy), 128'(0));
      if (rdy_q.size() == 0) begin
        chk("unexpected_rdy", 128'(i_rdy | d_rdy), 128'(0));
      end else begin
        e = rdy_q.pop_front();
        chk("rdy_port", 128'(d_rdy), 128'(e.is_d));
        chk("rdy_err", 128'(err), 128'(e.err));
        chk("rdy_rdata", rdata, e.rdata);
        if (e.cyc >= 0) chk("rdy_cycle", 128'(cyc), 128'(e.cyc));
      end
    end else if (err) begin
      chk("err_without_rdy", 128'(err), 128'(0));
    end
    rdy_prev = i_rdy | d_rdy;
  end

  // BRAM-side scoreboard: each rising mem_req is one transaction; fields hold until it ends.
  bit           mreq_prev = 0;
  logic [14:0]  cur_addr;
  logic [127:0] cur_wdata;
  always @(negedge HCLK) begin
    mem_exp_t m;
    if (mem_req && !mreq_prev) begin
      n_txn++;
      if (mem_q.size() == 0) begin
        chk("unexpected_txn", 128'(mem_req), 128'(0));
      end else begin
        m = mem_q.pop_front();
        chk("txn_write", 128'(mem_write), 128'(m.wr));
        chk("txn_addr", 128'(mem_addr), 128'(m.addr));
        chk("txn_wdata", mem_wdata, m.wdata);
      end
      cur_addr  = mem_addr;
      cur_wdata = mem_wdata;
    end else if (mem_req) begin
      chk("txn_addr_stable", 128'(mem_addr), 128'(cur_addr));
      chk("txn_wdata_stable", mem_wdata, cur_wdata);
    end
    mreq_prev = mem_req;
  end

  initial begin
    int t0;
    int txn0;
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    HRESETn = 0;
    i_req = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_req = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    mem_valid = 0; mem_rdata = '0;

    // Reset state
    step(); step();
    @(negedge HCLK);
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_mem_wdata", mem_wdata, 128'(0));
    chk("rst_rdy_err", 128'({i_rdy, d_rdy, err}), 128'(0));
    step();
    HRESETn = 1;
    step();

    // Single data read, BRAM answers at cycle 3
    resp_lat = 2; resp_data = a5;
    t0 = cyc;
    d_req = 1; d_write = 0; d_addr = 15'h0123; d_wdata = '0;
    expect_txn(1, 0, 15'h0123, '0);
    expect_rdy(1, 0, a5, t0 + 3);
    @(negedge HCLK);
    chk("t1_no_req_c0", 128'(mem_req), 128'(0));
    step();
    @(negedge HCLK);
    chk("t1_req_c1", 128'(mem_req), 128'(1));
    chk("t1_addr_c1", 128'(mem_addr), 128'(15'h0123));
    wait_rdy(1);
    d_req = 0;
    @(negedge HCLK);
    chk("t1_req_low_c4", 128'(mem_req), 128'(0));
    step();

    // Simultaneous requests: data first, then instruction
    resp_lat = 1; resp_data = {4{32'h1234_5678}};
    txn0 = n_txn;
    i_req = 1; i_write = 0; i_addr = 15'h0042; i_wdata = {4{32'hDEAD_0001}};
    d_req = 1; d_write = 1; d_addr = 15'h0100; d_wdata = {4{32'hCAFE_F00D}};
    expect_txn(1, 1, 15'h0100, {4{32'hCAFE_F00D}});
    expect_txn(0, 0, 15'h0042, {4{32'hDEAD_0001}});
    expect_rdy(1, 0, {4{32'h1234_5678}}, -1);
    expect_rdy(0, 0, {4{32'h1234_5678}}, -1);
    wait_rdy(1);
    d_req = 0;
    wait_rdy(0);
    i_req = 0;
    repeat (3) step();
    chk("t2_two_txns", 128'(n_txn - txn0), 128'(2));

    // Starvation limiter: 4 data grants, then instruction
    resp_lat = 1; resp_data = {8{16'h5A5A}};
    i_req = 1; i_write = 0; i_addr = 15'h0AAA; i_wdata = '0;
    d_req = 1; d_write = 0; d_addr = 15'h0200; d_wdata = {2{64'h1111_2222_3333_4444}};
    for (int n = 0; n < 4; n++) begin
      expect_txn(1, 0, 15'h0200, {2{64'h1111_2222_3333_4444}});
      expect_rdy(1, 0, {8{16'h5A5A}}, -1);
    end
    expect_txn(0, 0, 15'h0AAA, '0);
    expect_rdy(0, 0, {8{16'h5A5A}}, -1);
    expect_txn(1, 0, 15'h0200, {2{64'h1111_2222_3333_4444}});
    expect_rdy(1, 0, {8{16'h5A5A}}, -1);
    for (int n = 0; n < 4; n++) wait_rdy(1);
    @(negedge HCLK);
    chk("t3_streak_at_limit", 128'(dut.streak), 128'(4));
    step();
    @(negedge HCLK);
    chk("t3_streak_cleared", 128'(dut.streak), 128'(0));
    wait_rdy(0);
    i_req = 0;
    wait_rdy(1);
    d_req = 0;
    step();

    // In-flight protection: instruction write at 0x7FFF held while d_req rises
    resp_lat = 5; resp_data = {4{32'h0BAD_BEEF}};
    t0 = cyc;
    i_req = 1; i_write = 1; i_addr = 15'h7FFF; i_wdata = {4{32'h7777_8888}};
    expect_txn(0, 1, 15'h7FFF, {4{32'h7777_8888}});
    expect_txn(1, 0, 15'h0001, {4{32'h9999_AAAA}});
    expect_rdy(0, 0, {4{32'h0BAD_BEEF}}, t0 + 6);
    expect_rdy(1, 0, {4{32'h0BAD_BEEF}}, -1);
    step(); step();
    d_req = 1; d_write = 0; d_addr = 15'h0001; d_wdata = {4{32'h9999_AAAA}};
    step(); step(); step();
    @(negedge HCLK);
    chk("t4_addr_held", 128'(mem_addr), 128'(15'h7FFF));
    chk("t4_write_held", 128'(mem_write), 128'(1));
    wait_rdy(0);
    i_req = 0;
    wait_rdy(1);
    d_req = 0;
    step();

    // mem_valid coinciding with the timeout cycle is a success
    resp_lat = 63; resp_data = {2{64'h0123_4567_89AB_CDEF}};
    t0 = cyc;
    d_req = 1; d_write = 0; d_addr = 15'h0444; d_wdata = '0;
    expect_txn(1, 0, 15'h0444, '0);
    expect_rdy(1, 0, {2{64'h0123_4567_89AB_CDEF}}, t0 + 64);
    wait_rdy(1);
    d_req = 0;
    step();

    // Timeout: BRAM never answers
    resp_en = 0; resp_data = {16{8'h3C}};
    t0 = cyc;
    d_req = 1; d_write = 0; d_addr = 15'h0555; d_wdata = '0;
    expect_txn(1, 0, 15'h0555, '0);
    expect_rdy(1, 1, '0, t0 + 64);
    wait_rdy(1);
    d_req = 0;
    step();
    resp_en = 1; resp_lat = 2;
    i_req = 1; i_write = 0; i_addr = 15'h0321; i_wdata = '0;
    expect_txn(0, 0, 15'h0321, '0);
    expect_rdy(0, 0, {16{8'h3C}}, -1);
    wait_rdy(0);
    i_req = 0;
    step();

    // Reset during D_BUSY aborts silently
    resp_lat = 10; resp_data = {16{8'hE1}};
    i_req = 1; i_write = 0; i_addr = 15'h0010; i_wdata = '0;
    d_req = 1; d_write = 0; d_addr = 15'h0020; d_wdata = '0;
    expect_txn(1, 0, 15'h0020, '0);
    step();
    @(negedge HCLK);
    chk("t6_streak_before_rst", 128'(dut.streak), 128'(1));
    step();
    HRESETn = 0; i_req = 0; d_req = 0;
    step();
    @(negedge HCLK);
    chk("t6_mem_req_after_rst", 128'(mem_req), 128'(0));
    chk("t6_streak_after_rst", 128'(dut.streak), 128'(0));
    chk("t6_no_rdy", 128'({i_rdy, d_rdy}), 128'(0));
    step();
    HRESETn = 1; stray_valid = 1;
    @(negedge HCLK);
    chk("t6_stray_valid_seen", 128'(mem_valid), 128'(1));
    chk("t6_stray_no_rdy", 128'({i_rdy, d_rdy, err}), 128'(0));
    step();
    stray_valid = 0;
    repeat (4) step();

    chk("rdy_queue_drained", 128'(rdy_q.size()), 128'(0));
    chk("txn_queue_drained", 128'(mem_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
